// File: rtl/riscv_multicycle_ctrl_if.sv
// Control-path bundle between the multicycle RV32I control FSM and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface riscv_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       i_opcode;
  logic [2:0]       i_funct3;
  logic             i_zero;
  logic             i_mem_ready;
  logic             o_pc_write;
  logic             o_ir_write;
  logic             o_iord;
  logic             o_mem_read;
  logic             o_mem_write;
  logic             o_reg_write;
  logic [1:0]       o_alu_src_a;
  logic [1:0]       o_alu_src_b;
  logic [1:0]       o_alu_op;
  logic [1:0]       o_result_src;
  logic [CNT_W-1:0] o_retired;
  logic             o_illegal_instr;
  logic             o_bus_error;
  logic [3:0]       o_state;

  modport master (
    input  i_opcode, i_funct3, i_zero, i_mem_ready,
    output o_pc_write, o_ir_write, o_iord, o_mem_read, o_mem_write, o_reg_write,
           o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src,
           o_retired, o_illegal_instr, o_bus_error, o_state
  );

  modport slave (
    output i_opcode, i_funct3, i_zero, i_mem_ready,
    input  o_pc_write, o_ir_write, o_iord, o_mem_read, o_mem_write, o_reg_write,
           o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src,
           o_retired, o_illegal_instr, o_bus_error, o_state
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback,
// counts retired instructions and traps on illegal opcodes or memory timeouts.
module riscv_multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  riscv_multicycle_ctrl_if.master       io_ctrl
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  // The wait counter holds completed wait cycles, so it never needs to exceed TIMEOUT-1.
  localparam int              WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal, r_bus_err;
  logic [WC_W-1:0]  r_wcnt;

  logic       w_mem_wait, w_timeout, w_retire;
  logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write, w_reg_write;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;

  assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE))
                      && !io_ctrl.i_mem_ready;
  assign w_timeout  = TO_EN && w_mem_wait && (r_wcnt == WC_LAST);
  assign w_retire   = (w_next == S_FETCH) &&
                      (r_state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_JAL, S_LUI});

  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_result_src = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b10;
        if (io_ctrl.i_mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_result_src = 2'b10;
          w_next       = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (io_ctrl.i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_B:         w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = (io_ctrl.i_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (io_ctrl.i_mem_ready) w_next = S_MEMWB;
        else if (w_timeout)      w_next = S_TRAP;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_result_src = 2'b01;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (io_ctrl.i_mem_ready) w_next = S_FETCH;
        else if (w_timeout)      w_next = S_TRAP;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        // Only beq/bne are taken; other funct3 values fall through and still retire.
        w_pc_write  = ((io_ctrl.i_funct3 == 3'b000) &&  io_ctrl.i_zero) ||
                      ((io_ctrl.i_funct3 == 3'b001) && !io_ctrl.i_zero);
        w_next      = S_FETCH;
      end
      S_JAL: begin
        w_alu_src_a  = 2'b01;
        w_alu_src_b  = 2'b10;
        w_reg_write  = 1'b1;
        w_result_src = 2'b10;
        w_pc_write   = 1'b1;
        w_next       = S_FETCH;
      end
      S_LUI: begin
        w_reg_write  = 1'b1;
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_next       = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_wcnt    <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= (TO_EN && w_mem_wait && !w_timeout) ? r_wcnt + 1'b1 : '0;
      if (w_retire)                                r_retired <= r_retired + 1'b1;
      if (r_state == S_DECODE && w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_timeout)                               r_bus_err <= 1'b1;
    end
  end

  // Write strobes are forced low while reset is held, even though FETCH decode is live.
  assign io_ctrl.o_pc_write      = w_pc_write  & ~reset;
  assign io_ctrl.o_ir_write      = w_ir_write  & ~reset;
  assign io_ctrl.o_mem_write     = w_mem_write & ~reset;
  assign io_ctrl.o_reg_write     = w_reg_write & ~reset;
  assign io_ctrl.o_iord          = w_iord;
  assign io_ctrl.o_mem_read      = w_mem_read;
  assign io_ctrl.o_alu_src_a     = w_alu_src_a;
  assign io_ctrl.o_alu_src_b     = w_alu_src_b;
  assign io_ctrl.o_alu_op        = w_alu_op;
  assign io_ctrl.o_result_src    = w_result_src;
  assign io_ctrl.o_retired       = r_retired;
  assign io_ctrl.o_illegal_instr = r_illegal;
  assign io_ctrl.o_bus_error     = r_bus_err;
  assign io_ctrl.o_state         = r_state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: directed scenarios with literal expectations, then random
// instruction/memory-latency stimulus checked every cycle against an instruction-path model.
module tb_riscv_multicycle_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] LU  = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
  riscv_multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .io_ctrl(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instruction is FETCH, DECODE, then a per-opcode list of phases.
  // Phases 0/3/5 are memory phases that hold until ready (or time out).
  int m_phase = 0, m_wait = 0, m_ret = 0;
  bit m_ill = 0, m_bus = 0;
  int m_q[$];

  task automatic model_step();
    bit is_mem;
    is_mem = (m_phase == 0) || (m_phase == 3) || (m_phase == 5);
    if (m_phase == 15) return;
    if (is_mem && !bus.i_mem_ready) begin
      if (m_wait + 1 >= TIMEOUT) begin m_phase = 15; m_bus = 1; m_wait = 0; end
      else m_wait++;
      return;
    end
    m_wait = 0;
    if (m_phase == 0) m_phase = 1;
    else if (m_phase == 1) begin
      case (bus.i_opcode)
        LW:      m_q = '{2, 3, 4};
        SW:      m_q = '{2, 5};
        RT:      m_q = '{6, 8};
        IT:      m_q = '{7, 8};
        BR:      m_q = '{9};
        JL:      m_q = '{10};
        LU:      m_q = '{11};
        default: m_q.delete();
      endcase
      if (m_q.size() == 0) begin m_phase = 15; m_ill = 1; end
      else m_phase = m_q.pop_front();
    end else if (m_q.size() > 0) m_phase = m_q.pop_front();
    else begin
      m_phase = 0;
      m_ret   = (m_ret + 1) % (1 << CNT_W);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_phase = 0; m_wait = 0; m_ret = 0; m_ill = 0; m_bus = 0; m_q.delete();
    end else model_step();
  end

  // Expected control word {pcw,irw,iord,mr,mw,rw,sa,sb,op,rs} from the phase table.
  function automatic logic [13:0] exp_ctrl(input int ph, input logic rdy, input logic z,
                                           input logic [2:0] f3, input logic rst);
    logic pcw, irw, iord, mr, mw, rw;
    logic [1:0] sa, sb, op, rs;
    {pcw, irw, iord, mr, mw, rw} = '0;
    {sa, sb, op, rs} = '0;
    case (ph)
      0:  begin mr = 1; sb = 2; if (rdy) begin irw = 1; pcw = 1; rs = 2; end end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; rs = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 2; op = 2; end
      7:  begin sa = 2; sb = 1; op = 2; end
      8:  rw = 1;
      9:  begin sa = 2; op = 1; pcw = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z); end
      10: begin sa = 1; sb = 2; rw = 1; rs = 2; pcw = 1; end
      11: begin rw = 1; sb = 1; rs = 2; end
      default: ;
    endcase
    if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
    return {pcw, irw, iord, mr, mw, rw, sa, sb, op, rs};
  endfunction

  initial forever begin
    @(negedge clk);
    chk("ctrl", {bus.o_pc_write, bus.o_ir_write, bus.o_iord, bus.o_mem_read, bus.o_mem_write,
                 bus.o_reg_write, bus.o_alu_src_a, bus.o_alu_src_b, bus.o_alu_op, bus.o_result_src},
        exp_ctrl(m_phase, bus.i_mem_ready, bus.i_zero, bus.i_funct3, reset));
    chk("state", bus.o_state, m_phase);
    chk("retired", bus.o_retired, m_ret);
    chk("illegal", bus.o_illegal_instr, m_ill);
    chk("bus_err", bus.o_bus_error, m_bus);
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic rdy);
    bus.i_opcode = op; bus.i_funct3 = f3; bus.i_zero = z; bus.i_mem_ready = rdy;
  endtask

  // One cycle: drive inputs, check state (and optionally pc_write) mid-cycle, move past the edge.
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic z, input logic rdy,
                      input int exp_state, input int exp_pcw, input string nm);
    drive(op, f3, z, rdy);
    @(negedge clk);
    chk(nm, bus.o_state, exp_state);
    if (exp_pcw >= 0) chk({nm, "_pcw"}, bus.o_pc_write, exp_pcw);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int trap_cyc;
    reset = 1'b1;
    drive(RT, 3'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rst_state", bus.o_state, 0);
    chk("rst_memrd", bus.o_mem_read, 1);
    chk("rst_iord", bus.o_iord, 0);
    chk("rst_pcw", bus.o_pc_write, 0);
    chk("rst_irw", bus.o_ir_write, 0);
    chk("rst_ret", bus.o_retired, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // R-type with immediate memory
    step(RT, 0, 0, 1, 0, -1, "r_fetch");
    step(RT, 0, 0, 1, 1, -1, "r_decode");
    step(RT, 0, 0, 1, 6, -1, "r_exec");
    drive(RT, 0, 0, 1);
    @(negedge clk);
    chk("r_aluwb", bus.o_state, 8);
    chk("r_aluwb_rw", bus.o_reg_write, 1);
    @(posedge clk); #1;
    chk("r_retired", bus.o_retired, 1);

    // lw with three wait cycles in MEMREAD
    step(LW, 0, 0, 1, 0, -1, "lw_fetch");
    step(LW, 0, 0, 1, 1, -1, "lw_decode");
    step(LW, 0, 0, 1, 2, -1, "lw_memadr");
    for (int i = 0; i < 3; i++) step(LW, 0, 0, 0, 3, -1, "lw_wait");
    step(LW, 0, 0, 1, 3, -1, "lw_memread");
    step(LW, 0, 0, 1, 4, -1, "lw_memwb");
    chk("lw_retired", bus.o_retired, 2);

    // Branches: beq taken, beq not taken, bne taken
    step(BR, 0, 0, 1, 0, -1, "beq1_f");  step(BR, 0, 0, 1, 1, -1, "beq1_d");
    step(BR, 0, 1, 1, 9, 1, "beq_z1");
    step(BR, 0, 0, 1, 0, -1, "beq0_f");  step(BR, 0, 0, 1, 1, -1, "beq0_d");
    step(BR, 0, 0, 1, 9, 0, "beq_z0");
    step(BR, 1, 0, 1, 0, -1, "bne_f");   step(BR, 1, 0, 1, 1, -1, "bne_d");
    step(BR, 1, 0, 1, 9, 1, "bne_z0");
    chk("br_retired", bus.o_retired, 5);

    // Illegal opcode traps and stays trapped
    step(BAD, 0, 0, 1, 0, -1, "ill_f");
    step(BAD, 0, 0, 1, 1, -1, "ill_d");
    step(BAD, 0, 0, 1, 15, 0, "ill_trap");
    step(BAD, 0, 0, 1, 15, 0, "ill_hold");
    chk("ill_flag", bus.o_illegal_instr, 1);
    chk("ill_ret", bus.o_retired, 5);
    pulse_reset();
    chk("ill_clr", bus.o_illegal_instr, 0);

    // Fetch timeout, then the same with ready arriving on the last allowed cycle
    for (int i = 0; i < 4; i++) step(RT, 0, 0, 0, 0, -1, "to_wait");
    chk("to_state", bus.o_state, 15);
    chk("to_buserr", bus.o_bus_error, 1);
    pulse_reset();
    for (int i = 0; i < 3; i++) step(RT, 0, 0, 0, 0, -1, "nto_wait");
    step(RT, 0, 0, 1, 0, -1, "nto_ready");
    chk("nto_state", bus.o_state, 1);
    chk("nto_buserr", bus.o_bus_error, 0);
    step(RT, 0, 0, 1, 1, -1, "nto_d");
    step(RT, 0, 0, 1, 6, -1, "nto_e");
    step(RT, 0, 0, 1, 8, -1, "nto_wb");

    // Async reset in the middle of a stalled store
    step(SW, 0, 0, 1, 0, -1, "sw_f");
    step(SW, 0, 0, 1, 1, -1, "sw_d");
    step(SW, 0, 0, 1, 2, -1, "sw_a");
    drive(SW, 0, 0, 0);
    #2;
    chk("sw_state", bus.o_state, 5);
    chk("sw_mw", bus.o_mem_write, 1);
    reset = 1'b1;
    #1;
    chk("arst_state", bus.o_state, 0);
    chk("arst_mw", bus.o_mem_write, 0);
    chk("arst_ret", bus.o_retired, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Retired counter wraps after 16 instructions with CNT_W=4
    for (int n = 0; n < 16; n++) begin
      step(RT, 0, 0, 1, 0, -1, "wr_f");
      step(RT, 0, 0, 1, 1, -1, "wr_d");
      step(RT, 0, 0, 1, 6, -1, "wr_e");
      step(RT, 0, 0, 1, 8, -1, "wr_wb");
      if (n == 14) chk("wrap_15", bus.o_retired, 15);
    end
    chk("wrap_0", bus.o_retired, 0);

    // Random instruction mix with random memory latency
    trap_cyc = 0;
    for (int c = 0; c < 2000; c++) begin
      if (m_phase == 15) trap_cyc++; else trap_cyc = 0;
      reset = (trap_cyc >= 3);
      if (m_phase == 0) begin
        case ($urandom_range(0, 29))
          0, 1, 2, 3:     bus.i_opcode = LW;
          4, 5, 6, 7:     bus.i_opcode = SW;
          8, 9, 10, 11:   bus.i_opcode = RT;
          12, 13, 14, 15: bus.i_opcode = IT;
          16, 17, 18, 19, 20, 21: bus.i_opcode = BR;
          22, 23, 24:     bus.i_opcode = JL;
          25, 26, 27, 28: bus.i_opcode = LU;
          default:        bus.i_opcode = BAD;
        endcase
      end
      bus.i_funct3    = 3'($urandom_range(0, 3));
      bus.i_zero      = 1'($urandom_range(0, 1));
      bus.i_mem_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
Main control FSM for the multicycle variant of the RV32I core. It sequences a shared PC / instruction-data memory / register-file / ALU datapath through fetch, decode, execute, memory and writeback steps. Memory accesses complete with a ready handshake. The block also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
CNT_W, 32, width of retired-instruction counter
TIMEOUT, 255, max cycles waiting for mem_ready before bus-error trap; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  7  instr[6:0] from instruction register
funct3  in  3  instr[14:12] from instruction register
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  load PC this cycle
ir_write  out  1  load instruction register this cycle
iord  out  1  0 = memory address is PC; 1 = ALU-out register
mem_read  out  1  memory read request
mem_write  out  1  memory write request
reg_write  out  1  register-file write enable
alu_src_a  out  2  00 PC, 01 old PC, 10 rs1
alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4
alu_op  out  2  00 add, 01 sub, 10 decode from funct fields
result_src  out  2  00 ALU-out register, 01 memory data register, 10 ALU result
retired  out  CNT_W  count of completed instructions
illegal_instr  out  1  sticky trap flag: unsupported opcode
bus_error  out  1  sticky trap flag: memory timeout
state  out  4  current state encoding, for debug

Behaviour:
- Reset (async, any time, including mid-access): state=FETCH, retired=0, illegal_instr=0, bus_error=0, wait counter=0. Controls are decoded from FETCH, so mem_read=1 and iord=0 while reset is held; all write strobes are 0 while reset=1.
- All control outputs are combinational from state, mem_ready and zero/funct3. Undriven selects are 00.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11, TRAP=15.
- FETCH: mem_read=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00.
  - mem_ready=0: hold in FETCH.
  - mem_ready=1: ir_write=1, pc_write=1, result_src=10 (PC+4), then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> TRAP and set illegal_instr.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, result_src=01, then FETCH.
- MEMWRITE: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, then ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, then ALUWB.
- ALUWB: reg_write=1, result_src=00, then FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, then FETCH.
  - pc_write = (funct3==000 & zero) | (funct3==001 & ~zero).
  - Any other funct3: no PC write, instruction still retires.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, reg_write=1, result_src=10 (rd=oldPC+4). pc_write=1 with target from the ALU-out register (result_src mux path owned by the datapath). Then FETCH.
- LUI: reg_write=1, alu_src_a=00, alu_src_b=01, alu_op=00, result_src=10. The datapath zeroes operand A for LUI. Then FETCH.
- TRAP: all strobes 0, terminal until reset.
- Retired counter:
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, JAL or LUI.
  - Wraps modulo 2^CNT_W.
  - Does not increment on the TRAP path.
- Memory timeout:
  - The wait counter counts consecutive cycles in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - It clears on mem_ready=1 or on any state change.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with mem_ready still 0, go to TRAP and set bus_error. Outputs are the normal wait outputs during that cycle.
  - mem_ready=1 in the same cycle as the counter reaching TIMEOUT: the access completes and there is no error.
- CPI: R/I/LUI/JAL/branch take 3–4 cycles, sw 4, lw 5, plus memory wait cycles.

Test Plan:
- Reset then R-type: opcode=0110011, mem_ready=1 always -> states 0,1,6,8,0; reg_write high only in ALUWB; retired=1 after 4 cycles.
- lw with memory wait: opcode=0000011, mem_ready held low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with mem_read=1, iord=1; then MEMWB with reg_write=1, result_src=01; retired increments once.
- Branches: beq with zero=1 -> pc_write=1 in BRANCH. beq with zero=0 -> pc_write=0. bne with zero=0 -> pc_write=1. retired increments each time.
- Illegal opcode 1111111 -> DECODE then TRAP (state=15); illegal_instr=1 persists; all strobes 0; retired frozen; reset clears the trap.
- Timeout with TIMEOUT=4: mem_ready=0 in FETCH -> TRAP after 4 wait cycles, bus_error=1. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no error.
- Async reset asserted mid-MEMWRITE (between clock edges) -> state=0 and counters 0 immediately, mem_write drops without a clock edge; counter wrap with CNT_W=4 after 16 instructions -> retired=0.
